pe_l_vec: RTL
=============

PE_L_VEC -- requirements
Module: pe_l_vec

Interface
REQ-001 SHALL have parameter INT_BW, default 5: integer bits of the Q-format operand.
REQ-002 SHALL have parameter FRA_BW, default 10: fraction bits of the operand; MUL_BW = 1+INT_BW+FRA_BW.
REQ-003 SHALL have parameter MUL_BW, default 16: operand width.
REQ-004 SHALL have parameter ACC_BW, default 32: accumulator width, fraction 2*FRA_BW.
REQ-005 SHALL have parameter LANES, default 4: parallel lanes sharing one coefficient.
REQ-006 SHALL have parameter MAX_TERMS, default 8: maximum polynomial terms; TERM_W = clog2(MAX_TERMS+1).
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 mode  in  2  00 gemm, 01 poly (Horner); 10/11 treated as 01.
REQ-010 terms  in  TERM_W  polynomial term count, sampled on first poly beat.
REQ-011 in_valid / in_ready  in / out  1 each  input beat handshake.
REQ-012 wc_i  in  MUL_BW  signed weight (gemm) or coefficient (poly), shared by all lanes.
REQ-013 x_i  in  LANES*MUL_BW  signed per-lane operand, lane 0 in LSBs.
REQ-014 acc_i  in  LANES*ACC_BW  signed per-lane addend (gemm only).
REQ-015 out_valid / out_ready  out / in  1 each  result handshake.
REQ-016 o_o  out  LANES*ACC_BW  signed per-lane result.
REQ-017 sat_o  out  LANES  per-lane sticky saturation flag for current result.
REQ-018 busy  out  1  high when state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ITER, DONE; a beat is accepted when in_valid & in_ready.
REQ-020 in_ready SHALL be 1 in IDLE and ITER, 1 in DONE only when out_ready & mode==00, else 0.
REQ-021 out_valid SHALL equal (state==DONE); o_o and sat_o SHALL be held stable while out_valid & ~out_ready.
REQ-022 Gemm: accepted beat SHALL register o_lane = wc_i*x_lane + acc_lane (full product, ACC_BW two's-complement wrap), sat_o=0, enter DONE; latency 1 cycle.
REQ-023 Gemm in DONE: out_ready & accepted beat SHALL load the new result and stay DONE (full throughput); out_ready without beat -> IDLE.
REQ-024 Poly first beat (from IDLE): latch x_lane and remaining = max(terms,1)-1; acc_lane = sext(wc_i) << FRA_BW; sat_o cleared; next state ITER if remaining>0, else DONE.
REQ-025 Poly ITER beat: acc_lane = t_lane*x_lane + (sext(wc_i) << FRA_BW), remaining decrements; enter DONE when it reaches 0.
REQ-026 t_lane = acc_lane arithmetically shifted right FRA_BW, clamped to [-(2^(MUL_BW-1)), 2^(MUL_BW-1)-1]; any clamp SHALL set sat_o[lane].
REQ-027 Coefficients SHALL arrive highest-order first; x_i and acc_i SHALL be ignored on ITER beats.
REQ-028 Poly DONE SHALL return to IDLE on out_ready; no beat is accepted in DONE in poly mode.
REQ-029 mode and terms SHALL be sampled only on a beat accepted in IDLE; mode changes during ITER/DONE SHALL not affect the operation in flight, except REQ-020/023 gating in DONE.
REQ-030 terms > MAX_TERMS SHALL be clamped to MAX_TERMS.
REQ-031 Poly result o_o SHALL be acc_lane with 2*FRA_BW fraction bits; Horner accumulation SHALL wrap at ACC_BW.

Reset
REQ-032 rst high SHALL asynchronously force state IDLE, out_valid=0, o_o=0, sat_o=0, busy=0, remaining=0, latched x=0.
REQ-033 in_ready SHALL be 0 while rst is high; an operation interrupted by reset SHALL be discarded without output.

Verification
REQ-034 Gemm: wc_i=2, x={3,-4,5,0}, acc={10,10,10,10}, out_ready=1 -> next cycle out_valid=1, o_o={16,2,20,10}, sat_o=0.
REQ-035 Poly: terms=3, x=1024 (1.0) all lanes, coefs 1024,2048,3072 -> out_valid the cycle after the 3rd beat, o_o=6291456 (6.0) each lane, sat_o=0.
REQ-036 Saturation: terms=3, x=2048, coefs 31744,31744,0 -> t clamps to 32767 on 3rd beat, o_o=67106816, sat_o=all 1.
REQ-037 Backpressure: gemm result with out_ready=0 for 5 cycles -> o_o stable, in_ready=0, busy=1; out_ready=1 -> in_ready=1, back-to-back beats yield one result per cycle.
REQ-038 terms=0 and terms=1 with coef 1024 -> single-beat op, o_o=1048576; terms=15 -> exactly 8 beats consumed.
REQ-039 rst pulse during ITER after 2 of 4 beats -> out_valid=0, state IDLE; a new 3-term op then yields REQ-035 result.

Source files
------------

// File: rtl/pe_l_vec.sv
// pe_l_vec: multi-lane fixed-point PE doing one-beat GEMM MACs or Horner polynomial evaluation
// with a shared weight/coefficient, valid/ready on both sides.
module pe_l_vec #(
  parameter int INT_BW = 5,
  parameter int FRA_BW = 10,
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 32,
  parameter int LANES = 4,
  parameter int MAX_TERMS = 8,
  localparam int TERM_W = $clog2(MAX_TERMS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic [TERM_W-1:0]         terms,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MUL_BW-1:0]         wc_i,
  input  logic [LANES*MUL_BW-1:0]   x_i,
  input  logic [LANES*ACC_BW-1:0]   acc_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ACC_BW-1:0]   o_o,
  output logic [LANES-1:0]          sat_o,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  localparam logic signed [ACC_BW-1:0] T_MAX = (ACC_BW'(1) << (INT_BW + FRA_BW)) - ACC_BW'(1);
  localparam logic signed [ACC_BW-1:0] T_MIN = ~T_MAX;
  state_t r_state, w_next;
  logic r_poly;
  logic [TERM_W-1:0] r_rem, w_tc, w_rem0;
  logic w_fire, w_ld_gemm, w_ld_first, w_ld_iter;
  logic signed [ACC_BW-1:0] w_c;
  // a poly result in DONE never accepts a beat, whatever mode is presented now
  assign in_ready = ~rst & (r_state != DONE | (out_ready & mode == 2'b00 & ~r_poly));
  assign w_fire = in_valid & in_ready;
  assign out_valid = r_state == DONE;
  assign busy = r_state != IDLE;
  assign w_tc = terms > TERM_W'(MAX_TERMS) ? TERM_W'(MAX_TERMS) : terms;
  assign w_rem0 = w_tc == '0 ? '0 : w_tc - TERM_W'(1);
  assign w_ld_gemm = w_fire & (r_state == DONE | (r_state == IDLE & mode == 2'b00));
  assign w_ld_first = w_fire & r_state == IDLE & mode != 2'b00;
  assign w_ld_iter = w_fire & r_state == ITER;
  assign w_c = {{(ACC_BW-MUL_BW){wc_i[MUL_BW-1]}}, wc_i} << FRA_BW;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_fire) w_next = (mode == 2'b00 || w_rem0 == '0) ? DONE : ITER;
      ITER: if (w_fire && r_rem == TERM_W'(1)) w_next = DONE;
      DONE: if (out_ready) w_next = w_fire ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_poly <= 1'b0;
      r_rem <= '0;
    end else if (w_ld_first) begin
      r_poly <= 1'b1;
      r_rem <= w_rem0;
    end else if (w_ld_gemm) begin
      r_poly <= 1'b0;
    end else if (w_ld_iter) begin
      r_rem <= r_rem - TERM_W'(1);
    end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [MUL_BW-1:0] w_x, r_x, w_t;
    logic signed [ACC_BW-1:0] r_acc, w_sh, w_gemm, w_horn;
    logic signed [2*MUL_BW-1:0] w_gp, w_hp;
    logic w_hi, w_lo, r_s;
    assign w_x = x_i[g*MUL_BW +: MUL_BW];
    assign w_gp = $signed(wc_i) * w_x;
    assign w_gemm = w_gp + $signed(acc_i[g*ACC_BW +: ACC_BW]);
    // Horner feedback: drop the extra fraction bits and clamp back to operand range
    assign w_sh = r_acc >>> FRA_BW;
    assign w_hi = w_sh > T_MAX;
    assign w_lo = w_sh < T_MIN;
    assign w_t = w_hi ? T_MAX[MUL_BW-1:0] : w_lo ? T_MIN[MUL_BW-1:0] : w_sh[MUL_BW-1:0];
    assign w_hp = w_t * r_x;
    assign w_horn = w_hp + w_c;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_x <= '0;
        r_acc <= '0;
        r_s <= 1'b0;
      end else if (w_ld_gemm) begin
        r_acc <= w_gemm;
        r_s <= 1'b0;
      end else if (w_ld_first) begin
        r_x <= w_x;
        r_acc <= w_c;
        r_s <= 1'b0;
      end else if (w_ld_iter) begin
        r_acc <= w_horn;
        r_s <= r_s | w_hi | w_lo;
      end
    assign o_o[g*ACC_BW +: ACC_BW] = r_acc;
    assign sat_o[g] = r_s;
  end
endmodule
